// File: rtl/bios_rx.sv
// Purpose: receives BIOS image blocks from a loader into a 64-word buffer, then writes them to word memory.
// Latency: 65-cycle FILL per block (BIOS_REQ high 64 cycles), then one write per mem_ready cycle.
// Backpressure: mem_ready=0 stalls DRAIN with mem_wr/mem_addr/mem_data held; the loader is paced by BIOS_REQ.
//
// Ports:
//   clk_sdr, rst_n      clock and asynchronous active-low reset (release synchronised internally)
//   load_start          one-cycle pulse: abort any block in flight, restart the image at word 0
//   BIOS_WR             loader level: a block is ready (must be seen low before each new block)
//   BIOS_DIN[15:0]      loader data, valid one cycle after each BIOS_REQ-high cycle
//   BIOS_REQ            high for 64 consecutive cycles per block
//   mem_wr/mem_addr/mem_data/mem_ready   memory write port, accepted when mem_wr && mem_ready
//   busy, done          busy in FILL/DRAIN; done once all BLOCKS blocks are written
//   checksum[15:0]      only with BIOS_RX_CHECKSUM_EN: 16-bit sum of all accepted words
//
// Optional feature macro: BIOS_RX_CHECKSUM_EN
module bios_rx #(
   parameter int BLOCKS = 128
) (
   input  logic        clk_sdr,
   input  logic        rst_n,
   input  logic        load_start,
   input  logic        BIOS_WR,
   input  logic [15:0] BIOS_DIN,
   output logic        BIOS_REQ,
   output logic        mem_wr,
   output logic [12:0] mem_addr,
   output logic [15:0] mem_data,
   input  logic        mem_ready,
   output logic        busy,
`ifdef BIOS_RX_CHECKSUM_EN
   output logic        done,
   output logic [15:0] checksum
`else
   output logic        done
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_DRAIN, S_DONE} state_t;

   localparam logic [6:0] BLK_LAST = 7'(BLOCKS - 1);

   state_t      state;
   state_t      state_nxt;
   logic [1:0]  rst_sync;
   logic        rst_ok;
   logic        armed;
   logic [6:0]  fcnt;      // FILL cycle number f0..f64; bit 6 marks the final capture cycle
   logic [5:0]  idx;       // DRAIN word index
   logic [6:0]  blk;       // blocks completed so far
   logic [5:0]  buf_wa;
   logic        wr_accept;
   logic        fill_start;
   logic [15:0] blk_buf [64];

   // Reset asserts asynchronously but is held internally for two edges after release,
   // so no state (including armed) can move until the release has been synchronised.
   always_ff @(posedge clk_sdr or negedge rst_n) begin
      if (!rst_n) rst_sync <= 2'b00;
      else        rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_ok = rst_sync[1];

   always_ff @(posedge clk_sdr or negedge rst_n) begin
      if (!rst_n)       state <= S_IDLE;
      else if (!rst_ok) state <= S_IDLE;
      else              state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      BIOS_REQ  = 1'b0;
      mem_wr    = 1'b0;
      mem_addr  = '0;
      mem_data  = '0;
      busy      = 1'b0;
      done      = 1'b0;
      wr_accept = 1'b0;
      case (state)
         S_IDLE: begin
            if (BIOS_WR && armed) state_nxt = S_FILL;
         end
         S_FILL: begin
            busy     = 1'b1;
            BIOS_REQ = ~fcnt[6];
            // f64 only captures the last word; DRAIN follows directly
            if (fcnt[6]) state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            busy      = 1'b1;
            mem_wr    = 1'b1;
            mem_addr  = {blk, idx};
            mem_data  = blk_buf[idx];
            wr_accept = mem_ready;
            if (mem_ready && idx == 6'd63) state_nxt = (blk == BLK_LAST) ? S_DONE : S_IDLE;
         end
         S_DONE: begin
            done = 1'b1;
         end
         default: state_nxt = S_IDLE;
      endcase
      if (load_start) state_nxt = S_IDLE;
   end

   assign fill_start = (state == S_IDLE) && (state_nxt == S_FILL);

   always_ff @(posedge clk_sdr or negedge rst_n) begin
      if (!rst_n) begin
         armed <= 1'b0;
         fcnt  <= '0;
         idx   <= '0;
         blk   <= '0;
      end else if (!rst_ok) begin
         armed <= 1'b0;
         fcnt  <= '0;
         idx   <= '0;
         blk   <= '0;
      end else begin
         // armed survives load_start: a level held high across the restart still needs a low phase
         if (!BIOS_WR)        armed <= 1'b1;
         else if (fill_start) armed <= 1'b0;

         if (load_start) begin
            fcnt <= '0;
            idx  <= '0;
            blk  <= '0;
         end else begin
            fcnt <= (state == S_FILL && !fcnt[6]) ? fcnt + 7'd1 : 7'd0;
            if (wr_accept) begin
               idx <= idx + 6'd1;
               // the final block leaves the counter at BLOCKS-1 so it never wraps
               if (idx == 6'd63 && blk != BLK_LAST) blk <= blk + 7'd1;
            end
         end
      end
   end

   // Word for cycle f(n) lands at index n-1
   assign buf_wa = 6'(fcnt - 7'd1);

   always_ff @(posedge clk_sdr) begin
      if (state == S_FILL && fcnt != 7'd0) blk_buf[buf_wa] <= BIOS_DIN;
   end

`ifdef BIOS_RX_CHECKSUM_EN
   always_ff @(posedge clk_sdr or negedge rst_n) begin
      if (!rst_n)                 checksum <= '0;
      else if (!rst_ok)           checksum <= '0;
      else if (load_start)        checksum <= '0;
      else if (wr_accept && !done) checksum <= checksum + mem_data;
   end
`endif

endmodule
